// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - streams program bytes into instruction memory, pads to a word boundary, holds the CPU until loaded
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    byte_in,
  input  logic                     byte_valid,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic                     WE,
  output logic [ADDRESS_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0]    WD,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} state_t;

  localparam logic [MEM_ADDR_WIDTH-1:0] CNT_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEM_ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                    state, state_next;
  logic [MEM_ADDR_WIDTH-1:0] cnt, cnt_inc;
  logic                      wr, cnt_clr;
  logic [DATA_WIDTH-1:0]     wr_data;

  assign cnt_inc = cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr         = 1'b0;
    wr_data    = '0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          cnt_clr    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          wr      = 1'b1;
          wr_data = byte_in;
          // the last byte at the top address wraps cnt_inc to 0, so it lands in DONE
          if (byte_last)
            state_next = (cnt_inc[1:0] == 2'b00) ? DONE : PAD;
          else if (cnt == CNT_MAX)
            state_next = ERR;
        end
      end
      PAD: begin
        wr = 1'b1;
        if (cnt_inc[1:0] == 2'b00) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      WE  <= 1'b0;
      A   <= '0;
      WD  <= '0;
    end else begin
      WE <= wr;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (wr) begin
        cnt <= cnt_inc;
        A   <= ADDRESS_WIDTH'(cnt);
        WD  <= wr_data;
      end
    end
  end

  // DONE is entered on the edge that launches the final write; done waits for that pulse to retire
  assign done       = (state == DONE) && !WE;
  assign cpu_hold   = !done;
  assign err        = (state == ERR);
  assign byte_ready = (state == LOAD);

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic        byte_valid = 1'b0, byte_last = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_ready, WE, cpu_hold, done, err;
  logic [31:0] A;
  logic [7:0]  WD;

  instr_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .WE(WE), .A(A), .WD(WD),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int d; } wr_t;
  typedef struct { bit st; logic [7:0] d; bit v; bit l; int ea; } vec_t;

  wr_t sb[$];
  int  pass_cnt = 0, total_cnt = 0, cyc = 0, last_we_cyc = 0;
  bit  done_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (WE) begin
      if (sb.size() == 0) check("unexpected_we", 1, 0);
      else begin
        e = sb.pop_front();
        check("wr_addr", A, e.a);
        check("wr_data", {24'd0, WD}, e.d);
      end
      last_we_cyc = cyc;
    end
    if (done && !done_q) begin
      check("done_after_last_we", cyc - last_we_cyc, 1);
      check("cpu_hold_in_done", cpu_hold, 0);
    end
    done_q = done;
  end

  task automatic drive(input logic [7:0] d, input bit v, input bit l, input int ea);
    byte_in = d; byte_valid = v; byte_last = l;
    if (ea >= 0) begin
      sb.push_back('{ea, int'(d)});
      if (l) for (int p = ea + 1; p % 4 != 0; p++) sb.push_back('{p, 0});
    end
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'($urandom);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ready", byte_ready, 1);
    check("start_done_low", done, 0);
    check("start_err_low", err, 0);
    check("start_hold", cpu_hold, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("done_seen", done, 1);
    check("sb_drained", sb.size(), 0);
    check("err_low_at_done", err, 0);
  endtask

  vec_t vecs[20];

  initial begin
    vecs = '{
      '{1, 8'h13, 1, 0, 0}, '{0, 8'h05, 1, 0, 1}, '{0, 8'h10, 1, 0, 2}, '{0, 8'h00, 1, 0, 3},
      '{0, 8'h93, 1, 0, 4}, '{0, 8'h05, 1, 0, 5}, '{0, 8'h00, 1, 0, 6}, '{0, 8'h00, 1, 1, 7},
      '{1, 8'ha1, 1, 0, 0}, '{0, 8'ha2, 1, 0, 1}, '{0, 8'ha3, 1, 0, 2}, '{0, 8'ha4, 1, 0, 3},
      '{0, 8'ha5, 1, 1, 4},
      '{1, 8'hb0, 1, 0, 0}, '{0, 8'hb1, 0, 0, -1}, '{0, 8'hb2, 0, 1, -1}, '{0, 8'hb3, 1, 0, 1},
      '{0, 8'hb4, 1, 0, 2}, '{0, 8'hb5, 0, 1, -1}, '{0, 8'hb6, 1, 1, 3}
    };

    #2 rst = 1'b1;
    #1;
    check("rst_we", WE, 0);       check("rst_a", A, 0);        check("rst_wd", WD, 0);
    check("rst_ready", byte_ready, 0); check("rst_done", done, 0);
    check("rst_err", err, 0);     check("rst_hold", cpu_hold, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("idle_ready", byte_ready, 0);

    foreach (vecs[i]) begin
      if (vecs[i].st) do_start();
      drive(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].ea);
      if (vecs[i].v && vecs[i].l) wait_done();
    end

    // start during LOAD is ignored, start in DONE reloads from 0
    do_start();
    drive(8'h11, 1, 0, 0);
    drive(8'h22, 1, 0, 1);
    start = 1'b1;
    drive(8'h33, 1, 0, 2);
    start = 1'b0;
    drive(8'h44, 1, 1, 3);
    wait_done();
    do_start();
    for (int i = 0; i < 4; i++) drive(8'h50 + 8'(i), 1, i == 3, i);
    wait_done();

    // asynchronous reset in the middle of a load
    do_start();
    for (int i = 0; i < 3; i++) drive(8'h60 + 8'(i), 1, 0, i);
    rst = 1'b1;
    #1;
    check("midrst_we", WE, 0);    check("midrst_a", A, 0);     check("midrst_wd", WD, 0);
    check("midrst_ready", byte_ready, 0); check("midrst_hold", cpu_hold, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) drive(8'h70 + 8'(i), 1, i == 3, i);
    wait_done();
    check("reload_final_a", A, 3);

    // overflow: 4097 bytes without last
    do_start();
    for (int i = 0; i < 4097; i++) begin
      drive(8'(i * 7), 1, 0, (i < 4096) ? i : -1);
      if (i == 4095) begin
        check("ovf_err", err, 1);
        check("ovf_ready", byte_ready, 0);
      end
    end
    repeat (3) @(negedge clk);
    check("ovf_sb_drained", sb.size(), 0);
    check("ovf_err_held", err, 1);
    check("ovf_done_low", done, 0);
    check("ovf_hold", cpu_hold, 1);

    // last byte at the top address completes instead of erroring
    do_start();
    for (int i = 0; i < 4096; i++) drive(8'(i * 3), 1, i == 4095, i);
    wait_done();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, meaning the width of the memory write address output.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of the byte stream and the memory write data.
REQ-003 The block SHALL have parameter MEM_ADDR_WIDTH, default 12, meaning the number of implemented address bits, giving 2**MEM_ADDR_WIDTH bytes.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a load session.
REQ-007 The block SHALL have port byte_in, input, DATA_WIDTH bits: incoming program byte, little-endian byte order.
REQ-008 The block SHALL have port byte_valid, input, 1 bit: byte_in holds a valid byte.
REQ-009 The block SHALL have port byte_last, input, 1 bit: qualified by byte_valid, marks the final byte.
REQ-010 The block SHALL have port byte_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 The block SHALL have port WE, output, 1 bit: instruction-memory byte write enable.
REQ-012 The block SHALL have port A, output, ADDRESS_WIDTH bits: the write byte address.
REQ-013 The block SHALL have port WD, output, DATA_WIDTH bits: the write data byte.
REQ-014 The block SHALL have port cpu_hold, output, 1 bit: holds the CPU in reset while the program is not loaded.
REQ-015 The block SHALL have port done, output, 1 bit: the load completed successfully.
REQ-016 The block SHALL have port err, output, 1 bit: memory overflow occurred.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, PAD, DONE and ERR, and SHALL enter IDLE on reset.
REQ-018 In IDLE, when start=1, the block SHALL clear the byte address counter to 0 and go to LOAD.
REQ-019 byte_ready SHALL be 1 only in LOAD; a handshake is byte_valid and byte_ready both 1 on the same edge.
REQ-020 For each handshake at edge t, WE SHALL be 1 for exactly one cycle after edge t, with A equal to the counter value and WD equal to byte_in; the counter SHALL then increment by 1.
REQ-021 The write outputs (WE, A, WD) SHALL be registered, giving a latency of 1 cycle from handshake to WE.
REQ-022 With no handshake and not in PAD, WE SHALL be 0; A and WD SHALL hold their previous values.
REQ-023 A SHALL be the counter zero-extended from MEM_ADDR_WIDTH to ADDRESS_WIDTH.
REQ-024 On a handshake with byte_last=1: if the incremented counter mod 4 is 0, the FSM SHALL go to DONE; otherwise it SHALL go to PAD.
REQ-025 In PAD, each cycle SHALL schedule one WD=0x00 write at the next consecutive address, until the counter is a multiple of 4; the FSM SHALL then go to DONE.
REQ-026 done SHALL first be 1 in the cycle immediately after the final WE pulse.
REQ-027 On a handshake at counter=2**MEM_ADDR_WIDTH-1: with byte_last=0, the byte SHALL be written and the FSM SHALL go to ERR; with byte_last=1, the FSM SHALL go to DONE.
REQ-028 done SHALL be 1 only in DONE, and err SHALL be 1 only in ERR.
REQ-029 cpu_hold SHALL be 0 only in DONE, and 1 in every other state.
REQ-030 start SHALL be ignored in LOAD and PAD.
REQ-031 start in DONE or ERR SHALL clear the counter and go to LOAD, with done and err deasserting on the next edge.
REQ-032 byte_in and byte_last SHALL be ignored when no handshake occurs.

Reset
REQ-033 While rst=1, regardless of clk, the block SHALL force state=IDLE, counter=0, WE=0, A=0, WD=0, byte_ready=0, done=0, err=0 and cpu_hold=1.
REQ-034 When rst asserts mid-LOAD or mid-PAD, any pending write SHALL be dropped and no WE pulse SHALL follow.

Verification
REQ-035 Reset, start, then 8 back-to-back bytes 0x13,0x05,0x10,0x00,0x93,0x05,0x00,0x00 with byte_last on the 8th -> WE pulses at A=0..7 with matching WD, no padding, done=1 and cpu_hold=0 one cycle after the A=7 write.
REQ-036 Start, then 5 bytes with byte_last on the 5th -> writes at A=0..4, then WD=0x00 at A=5,6,7 on consecutive cycles, then done=1.
REQ-037 Start, then bytes with byte_valid toggling 1,0,0,1,1,0,1 -> WE pulses only after handshake cycles, A contiguous 0,1,2,3.
REQ-038 Start, then 4097 bytes, none with byte_last -> writes A=0..4095, err=1 and byte_ready=0 after the 4096th handshake, and the 4097th byte is never written.
REQ-039 Assert rst after 3 handshakes, release, then start and send 4 bytes with last -> outputs reset immediately while rst is high, and the new writes begin at A=0.
REQ-040 start pulsed during LOAD -> no effect; start pulsed in DONE -> done drops and reload begins at A=0.
